// File: rtl/vga_frame_scaler.sv
// vga_frame_scaler: frame-buffer fetch and integer upscaler for the VGA output.
// Walks the source image in row-major order with incremental counters. Each
// source pixel is repeated 2^SCALE_SHIFT times in x and y inside a window on
// the active area. RGB and syncs leave aligned after RD_LAT+2 cycles.
module vga_frame_scaler #(
   parameter int          SRC_W       = 320,
   parameter int          SRC_H       = 240,
   parameter int          SCALE_SHIFT = 2,
   parameter int          H_OFFSET    = 0,
   parameter int          V_OFFSET    = 32,
   parameter int          RD_LAT      = 1,
   parameter int          ADDR_W      = 18,
   parameter logic [11:0] BORDER      = 12'h000
) (
   input  logic              clk_vga,
   input  logic              reset_n,
   input  logic [10:0]       x_loc,
   input  logic [10:0]       y_loc,
   input  logic              h_sync_in,
   input  logic              v_sync_in,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [11:0]       rd_data,
   output logic [3:0]        RED_out,
   output logic [3:0]        GREEN_out,
   output logic [3:0]        BLUE_out,
   output logic              h_sync,
   output logic              v_sync
);

   localparam int WIN_W = SRC_W << SCALE_SHIFT;
   localparam int WIN_H = SRC_H << SCALE_SHIFT;
   localparam int LAT   = RD_LAT + 2;
   localparam int SX_W  = (SRC_W > 1) ? $clog2(SRC_W) : 1;

   localparam logic [12:0]            X_LO     = 13'(H_OFFSET);
   localparam logic [12:0]            Y_LO     = 13'(V_OFFSET);
   localparam logic [11:0]            WIN_W12  = 12'(WIN_W);
   localparam logic [11:0]            WIN_H12  = 12'(WIN_H);
   localparam logic [11:0]            X_END    = 12'(H_OFFSET + WIN_W);
   localparam logic [SX_W-1:0]        SX_LAST  = SX_W'(SRC_W - 1);
   localparam logic [SX_W-1:0]        SX_ONE   = 1;
   localparam logic [SCALE_SHIFT-1:0] SUB_ONE  = 1;
   localparam logic [ADDR_W-1:0]      ROW_STEP = ADDR_W'(SRC_W);

   logic [12:0]            x_rel, y_rel;
   logic                   in_cols, in_rows, in_win, line_end;
   logic [SCALE_SHIFT-1:0] sub_x, sub_y;
   logic [SX_W-1:0]        src_x;
   logic [ADDR_W-1:0]      row_base;
   logic [LAT-1:0]         win_pipe, hs_pipe, vs_pipe;
   logic [11:0]            rgb_q;

   // Window test by subtraction: the borrow bit flags "left of / above" the
   // window, so an offset of zero needs no always-true compare.
   assign x_rel    = {2'b00, x_loc} - X_LO;
   assign y_rel    = {2'b00, y_loc} - Y_LO;
   assign in_cols  = !x_rel[12] && (x_rel[11:0] < WIN_W12);
   assign in_rows  = !y_rel[12] && (y_rel[11:0] < WIN_H12);
   assign in_win   = in_cols && in_rows;
   // The column just past the window closes the scaled line; it is never in_win.
   assign line_end = ({1'b0, x_loc} == X_END) && in_rows;

   // Horizontal walk: issue row_base+src_x, advancing src_x every 2^SCALE_SHIFT pixels.
   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         sub_x   <= '0;
         src_x   <= '0;
         rd_addr <= '0;
      end else if (!in_cols) begin
         sub_x <= '0;
         src_x <= '0;
      end else if (in_win) begin
         rd_addr <= row_base + ADDR_W'(src_x);
         sub_x   <= sub_x + SUB_ONE;
         if (sub_x == '1)
            src_x <= (src_x == SX_LAST) ? '0 : src_x + SX_ONE;
      end
   end

   // Vertical walk: step row_base by one source row every 2^SCALE_SHIFT lines;
   // any row outside the window (incl. vertical blanking) rewinds to the top.
   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         sub_y    <= '0;
         row_base <= '0;
      end else if (!in_rows) begin
         sub_y    <= '0;
         row_base <= '0;
      end else if (line_end) begin
         sub_y <= sub_y + SUB_ONE;
         if (sub_y == '1)
            row_base <= row_base + ROW_STEP;
      end
   end

   // Delay line carrying window flag and syncs alongside the BRAM fetch.
   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n) begin
         win_pipe <= '0;
         hs_pipe  <= '0;
         vs_pipe  <= '0;
      end else begin
         win_pipe <= {win_pipe[LAT-2:0], in_win};
         hs_pipe  <= {hs_pipe[LAT-2:0], h_sync_in};
         vs_pipe  <= {vs_pipe[LAT-2:0], v_sync_in};
      end
   end

   // Output colour: BRAM pixel when the matching window flag arrives, else border.
   always_ff @(posedge clk_vga or negedge reset_n) begin
      if (!reset_n)
         rgb_q <= '0;
      else
         rgb_q <= win_pipe[RD_LAT] ? rd_data : BORDER;
   end

   assign RED_out   = rgb_q[11:8];
   assign GREEN_out = rgb_q[7:4];
   assign BLUE_out  = rgb_q[3:0];
   assign h_sync    = hs_pipe[LAT-1];
   assign v_sync    = vs_pipe[LAT-1];

endmodule
